// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings and pipeline stage records. The bus master, the
// slaves and the bench all import this package, so encodings are defined once.
//   HTRANS_* : transfer type codes (only IDLE and NONSEQ are used here)
//   HRESP_*  : response codes
//   HSIZE_*  : transfer size codes
//   a_stage_t / d_stage_t : address- and data-stage records of the master
// ---------------------------------------------------------------------------
package ahb_pkg;

    localparam int AHB_ADDR_W = 32;
    localparam int AHB_DATA_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Address stage: the command currently presented in the address phase.
    // 'cancelled' marks a command withdrawn from the bus after an ERROR.
    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic                  cancelled;
        logic [AHB_ADDR_W-1:0] addr;
        logic [AHB_DATA_W-1:0] wdata;
    } a_stage_t;

    // Data stage: the command whose data phase is on the bus. wdata is
    // already zero for reads and cancelled commands, so it drives hwdata as is.
    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic                  cancelled;
        logic [AHB_DATA_W-1:0] wdata;
    } d_stage_t;

    // Error-recovery sequencing for the master.
    typedef enum logic [1:0] {
        ERR_RUN    = 2'd0,  // normal operation
        ERR_CANCEL = 2'd1,  // A cancelled, waiting for it to drain through D
        ERR_RESP   = 2'd2   // cancelled response on the bus this cycle
    } err_state_t;

endpackage

// File: rtl/ahb_master_module_if.sv
// ---------------------------------------------------------------------------
// ahb_master_module_if
// Bundles the local command/response handshake and the AHB-Lite bus signals
// of the master.
//   master modport : the bus master (drives req_ready, rsp_*, haddr, hwrite,
//                    htrans, hsize, hwdata; receives req_*, hready, hresp,
//                    hrdata)
//   slave modport  : the environment facing the master (local controller
//                    plus decoder/slave mux), directions mirrored
// ---------------------------------------------------------------------------
interface ahb_master_module_if
    import ahb_pkg::*;
#(
    parameter int ADDR_W = AHB_ADDR_W,
    parameter int DATA_W = AHB_DATA_W
);

    // Local command / response side
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;

    // AHB-Lite side
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output haddr, hwrite, htrans, hsize, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  haddr, hwrite, htrans, hsize, hwdata,
        output hready, hresp, hrdata
    );

endinterface

// File: rtl/ahb_master_module.sv
// ---------------------------------------------------------------------------
// ahb_master_module
// Single-port AHB-Lite bus master. Accepts word read/write commands on a
// valid/ready interface, runs them through a two-stage (address/data)
// pipeline and returns one in-order response per accepted command.
// Ports:
//   hclk    : clock, rising edge
//   hresetn : synchronous active-low reset
//   bus     : ahb_master_module_if.master
//             req_valid/req_ready/req_write/req_addr/req_wdata : command in
//             rsp_valid/rsp_rdata/rsp_error                    : response out
//             haddr/hwrite/htrans/hsize/hwdata                 : AHB drive
//             hready/hresp/hrdata                              : AHB return
// Parameters ADDR_W/DATA_W must match the ahb_pkg record widths.
// ---------------------------------------------------------------------------
module ahb_master_module
    import ahb_pkg::*;
#(
    parameter int ADDR_W = AHB_ADDR_W,
    parameter int DATA_W = AHB_DATA_W
) (
    input  logic                hclk,
    input  logic                hresetn,
    ahb_master_module_if.master bus
);

    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] hrdata;

    a_stage_t          a_q;
    d_stage_t          d_q;
    logic [1:0]        htrans_q;
    err_state_t        err_state;
    logic              rsp_valid_q;
    logic              rsp_error_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic              err_blk;
    logic              req_ready;
    logic              accept;
    logic              advance;
    logic              d_done;
    logic              hresp_err;
    logic              err_first;
    logic              cancel_a;

    assign req_addr  = bus.req_addr;
    assign req_wdata = bus.req_wdata;
    assign hrdata    = bus.hrdata;

    assign err_blk   = (err_state != ERR_RUN);

    // Only combinational input-to-output path: a command can enter A only
    // on an edge where the pipeline advances and no cancel is pending.
    assign req_ready = bus.hready & ~err_blk;
    assign accept    = bus.req_valid & req_ready;
    assign advance   = bus.hready;
    assign hresp_err = (bus.hresp == HRESP_ERROR);

    // A cancelled command never went on the bus, so it completes without
    // waiting for hready.
    assign d_done    = d_q.valid & (bus.hready | d_q.cancelled);

    // First cycle of the two-cycle ERROR response for the transfer in D.
    assign err_first = d_q.valid & ~d_q.cancelled & ~bus.hready & hresp_err;
    assign cancel_a  = err_first & a_q.valid & ~a_q.cancelled;

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            // NOTE: the pipeline datapath is reset as well as the valid bits,
            // because it drives haddr/hwrite/hwdata straight onto the bus.
            a_q         <= '0;
            d_q         <= '0;
            htrans_q    <= HTRANS_IDLE;
            err_state   <= ERR_RUN;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            // NOTE: every assignment here is non-blocking, so all right-hand
            // sides see the pre-edge register values regardless of order.
            rsp_valid_q <= d_done;
            rsp_error_q <= d_done & (d_q.cancelled | hresp_err);
            rsp_rdata_q <= (d_done && !d_q.cancelled && !d_q.write && !hresp_err)
                           ? hrdata : '0;

            if (advance) begin
                d_q <= '{valid:     a_q.valid,
                         write:     a_q.write,
                         cancelled: a_q.cancelled,
                         wdata:     (a_q.write && !a_q.cancelled) ? a_q.wdata : '0};
                if (accept) begin
                    a_q <= '{valid:     1'b1,
                             write:     bus.req_write,
                             cancelled: 1'b0,
                             addr:      req_addr,
                             wdata:     req_wdata};
                    htrans_q <= HTRANS_NONSEQ;
                end else begin
                    a_q      <= '0;
                    htrans_q <= HTRANS_IDLE;
                end
            end else begin
                // Stall: only a cancelled D may leave, and an ERROR withdraws
                // the pending address phase while keeping the command in A.
                if (d_done) begin
                    d_q <= '0;
                end
                if (cancel_a) begin
                    a_q.cancelled <= 1'b1;
                    htrans_q      <= HTRANS_IDLE;
                end
            end

            case (err_state)
                ERR_RUN: begin
                    if (cancel_a) begin
                        err_state <= ERR_CANCEL;
                    end
                end
                ERR_CANCEL: begin
                    if (d_done && d_q.cancelled) begin
                        err_state <= ERR_RESP;
                    end
                end
                ERR_RESP: begin
                    err_state <= ERR_RUN;
                end
                default: begin
                    err_state <= ERR_RUN;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.haddr     = a_q.addr;
    assign bus.hwrite    = a_q.write;
    assign bus.htrans    = htrans_q;
    assign bus.hsize     = HSIZE_WORD;
    assign bus.hwdata    = d_q.wdata;

endmodule

// File: tb/tb_ahb_master_module.sv
// ---------------------------------------------------------------------------
// tb_ahb_master_module
// Self-checking bench for ahb_master_module: directed scenarios for reset,
// single transfers, back-to-back, wait states, error cancel and mid-transfer
// reset, then a randomized run against a memory reference model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_ahb_master_module;
    import ahb_pkg::*;

    logic hclk;
    logic hresetn;
    int   tests_run;
    int   tests_failed;

    ahb_master_module_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    ahb_master_module #(.ADDR_W(32), .DATA_W(32)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus_if)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference memories: the slave side is updated from hwdata at data-phase
    // completion, the model side at command acceptance. Both start from the
    // same address-derived contents.
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    task automatic next_cycle();
        @(posedge hclk);
        #1;
    endtask

    task automatic sample();
        @(negedge hclk);
    endtask

    task automatic idle_inputs();
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        bus_if.hready    = 1'b1;
        bus_if.hresp     = HRESP_OKAY;
        bus_if.hrdata    = $urandom;
    endtask

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = wr;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            idle_inputs();
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        hresetn = 1'b0;
        idle_inputs();
        repeat (3) next_cycle();
        sample();
        tests_run++; if (bus_if.htrans !== HTRANS_IDLE) begin tests_failed++; $display("FAIL rst_htrans: got %0h want %0h", bus_if.htrans, HTRANS_IDLE); end
        tests_run++; if (bus_if.haddr !== 32'h0) begin tests_failed++; $display("FAIL rst_haddr: got %0h want 0", bus_if.haddr); end
        tests_run++; if (bus_if.hwrite !== 1'b0) begin tests_failed++; $display("FAIL rst_hwrite: got %0b want 0", bus_if.hwrite); end
        tests_run++; if (bus_if.hwdata !== 32'h0) begin tests_failed++; $display("FAIL rst_hwdata: got %0h want 0", bus_if.hwdata); end
        tests_run++; if (bus_if.hsize !== HSIZE_WORD) begin tests_failed++; $display("FAIL rst_hsize: got %0b want %0b", bus_if.hsize, HSIZE_WORD); end
        tests_run++; if ({bus_if.rsp_valid, bus_if.rsp_error} !== 2'b00) begin tests_failed++; $display("FAIL rst_rsp_flags: got %0b%0b want 00", bus_if.rsp_valid, bus_if.rsp_error); end
        tests_run++; if (bus_if.rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_rsp_rdata: got %0h want 0", bus_if.rsp_rdata); end
        next_cycle();
        hresetn = 1'b1;
        bus_if.hready = 1'b0;
        sample();
        tests_run++; if (bus_if.req_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ready_lo: got %0b want 0", bus_if.req_ready); end
        next_cycle();
        bus_if.hready = 1'b1;
        sample();
        tests_run++; if (bus_if.req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready_hi: got %0b want 1", bus_if.req_ready); end
        tests_run++; if (bus_if.htrans !== HTRANS_IDLE) begin tests_failed++; $display("FAIL rst_idle_after: got %0h want %0h", bus_if.htrans, HTRANS_IDLE); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_single_write();
        next_cycle();
        drive_req(1'b1, 32'h10, 32'hDEAD_BEEF);
        sample();
        tests_run++; if (bus_if.req_ready !== 1'b1) begin tests_failed++; $display("FAIL sw_ready: got %0b want 1", bus_if.req_ready); end
        next_cycle();
        idle_inputs();
        sample();
        tests_run++; if (bus_if.htrans !== HTRANS_NONSEQ || bus_if.haddr !== 32'h10 || bus_if.hwrite !== 1'b1) begin tests_failed++; $display("FAIL sw_addr_phase: got htrans=%0h haddr=%0h hwrite=%0b want 2/10/1", bus_if.htrans, bus_if.haddr, bus_if.hwrite); end
        next_cycle();
        sample();
        tests_run++; if (bus_if.hwdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL sw_hwdata: got %0h want deadbeef", bus_if.hwdata); end
        tests_run++; if (bus_if.htrans !== HTRANS_IDLE || bus_if.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL sw_data_phase: got htrans=%0h rsp_valid=%0b want 0/0", bus_if.htrans, bus_if.rsp_valid); end
        next_cycle();
        sample();
        tests_run++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_error !== 1'b0 || bus_if.rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL sw_rsp: got v=%0b e=%0b d=%0h want 1/0/0", bus_if.rsp_valid, bus_if.rsp_error, bus_if.rsp_rdata); end
        next_cycle();
        sample();
        tests_run++; if (bus_if.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL sw_rsp_pulse: got %0b want 0", bus_if.rsp_valid); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_single_read();
        next_cycle();
        drive_req(1'b0, 32'h14, 32'hFFFF_FFFF);
        sample();
        next_cycle();
        idle_inputs();
        bus_if.hrdata = 32'hA5A5_0000;
        sample();
        tests_run++; if (bus_if.htrans !== HTRANS_NONSEQ || bus_if.haddr !== 32'h14 || bus_if.hwrite !== 1'b0) begin tests_failed++; $display("FAIL sr_addr_phase: got htrans=%0h haddr=%0h hwrite=%0b want 2/14/0", bus_if.htrans, bus_if.haddr, bus_if.hwrite); end
        next_cycle();
        bus_if.hrdata = 32'h1234_5678;
        sample();
        tests_run++; if (bus_if.hwdata !== 32'h0) begin tests_failed++; $display("FAIL sr_hwdata: got %0h want 0", bus_if.hwdata); end
        next_cycle();
        bus_if.hrdata = 32'h0BAD_0BAD;
        sample();
        tests_run++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_error !== 1'b0 || bus_if.rsp_rdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL sr_rsp: got v=%0b e=%0b d=%0h want 1/0/12345678", bus_if.rsp_valid, bus_if.rsp_error, bus_if.rsp_rdata); end
        idle_cycles(2);
    endtask

    // -----------------------------------------------------------------------
    // Command k is accepted at the end of cycle k; its address phase is
    // cycle k+1, data phase k+2 and response k+3.
    task automatic test_back_to_back();
        logic [31:0] addr [4];
        logic [31:0] wdat [4];
        for (int k = 0; k < 4; k++) begin
            addr[k] = 32'h100 + (32'($urandom_range(0, 63)) << 2);
            wdat[k] = $urandom;
        end
        for (int j = 0; j < 9; j++) begin
            next_cycle();
            if (j < 4) drive_req(1'b1, addr[j], wdat[j]);
            else       bus_if.req_valid = 1'b0;
            sample();
            if (j < 4) begin
                tests_run++; if (bus_if.req_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready[%0d]: got %0b want 1", j, bus_if.req_ready); end
            end
            if (j >= 1 && j <= 4) begin
                tests_run++; if (bus_if.htrans !== HTRANS_NONSEQ || bus_if.haddr !== addr[j-1]) begin tests_failed++; $display("FAIL b2b_addr[%0d]: got htrans=%0h haddr=%0h want 2/%0h", j, bus_if.htrans, bus_if.haddr, addr[j-1]); end
            end else begin
                tests_run++; if (bus_if.htrans !== HTRANS_IDLE) begin tests_failed++; $display("FAIL b2b_idle[%0d]: got %0h want 0", j, bus_if.htrans); end
            end
            tests_run++; if (bus_if.hwdata !== ((j >= 2 && j <= 5) ? wdat[j-2] : 32'h0)) begin tests_failed++; $display("FAIL b2b_hwdata[%0d]: got %0h want %0h", j, bus_if.hwdata, (j >= 2 && j <= 5) ? wdat[j-2] : 32'h0); end
            tests_run++; if (bus_if.rsp_valid !== (j >= 3 && j <= 6) || bus_if.rsp_error !== 1'b0) begin tests_failed++; $display("FAIL b2b_rsp[%0d]: got v=%0b e=%0b want %0b/0", j, bus_if.rsp_valid, bus_if.rsp_error, (j >= 3 && j <= 6)); end
        end
        idle_inputs();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_wait_states();
        logic [31:0] wd;
        wd = $urandom;
        next_cycle();
        drive_req(1'b0, 32'h20, 32'h0);
        sample();
        next_cycle();
        drive_req(1'b1, 32'h24, wd);
        sample();
        tests_run++; if (bus_if.req_ready !== 1'b1 || bus_if.haddr !== 32'h20) begin tests_failed++; $display("FAIL ws_second_accept: got ready=%0b haddr=%0h want 1/20", bus_if.req_ready, bus_if.haddr); end
        // Three stalled cycles of the read's data phase, then the completing one.
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            bus_if.req_valid = (c < 3);
            bus_if.req_addr  = 32'h28;
            bus_if.req_write = 1'b0;
            bus_if.hready    = (c == 3);
            bus_if.hrdata    = (c == 3) ? 32'hCAFE_F00D : $urandom;
            sample();
            tests_run++; if (bus_if.htrans !== HTRANS_NONSEQ || bus_if.haddr !== 32'h24 || bus_if.hwrite !== 1'b1 || bus_if.hwdata !== 32'h0) begin tests_failed++; $display("FAIL ws_hold[%0d]: got htrans=%0h haddr=%0h hwrite=%0b hwdata=%0h want 2/24/1/0", c, bus_if.htrans, bus_if.haddr, bus_if.hwrite, bus_if.hwdata); end
            tests_run++; if (bus_if.req_ready !== (c == 3)) begin tests_failed++; $display("FAIL ws_ready[%0d]: got %0b want %0b", c, bus_if.req_ready, (c == 3)); end
            tests_run++; if (bus_if.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL ws_no_rsp[%0d]: got %0b want 0", c, bus_if.rsp_valid); end
        end
        next_cycle();
        idle_inputs();
        sample();
        tests_run++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_error !== 1'b0 || bus_if.rsp_rdata !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL ws_read_rsp: got v=%0b e=%0b d=%0h want 1/0/cafef00d", bus_if.rsp_valid, bus_if.rsp_error, bus_if.rsp_rdata); end
        tests_run++; if (bus_if.hwdata !== wd || bus_if.htrans !== HTRANS_IDLE) begin tests_failed++; $display("FAIL ws_write_data: got hwdata=%0h htrans=%0h want %0h/0", bus_if.hwdata, bus_if.htrans, wd); end
        next_cycle();
        sample();
        tests_run++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL ws_write_rsp: got v=%0b d=%0h want 1/0", bus_if.rsp_valid, bus_if.rsp_rdata); end
        idle_cycles(2);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_error_cancel();
        int leaked;
        leaked = 0;
        next_cycle();
        drive_req(1'b1, 32'h00, 32'h1111_1111);
        sample();
        next_cycle();
        drive_req(1'b0, 32'h08, 32'h0);
        sample();
        tests_run++; if (bus_if.htrans !== HTRANS_NONSEQ || bus_if.haddr !== 32'h0) begin tests_failed++; $display("FAIL ec_write_addr: got htrans=%0h haddr=%0h want 2/0", bus_if.htrans, bus_if.haddr); end
        // Cycles 2..9: first error cycle, second error cycle, two responses,
        // then a fresh read of 0x0C that must run normally.
        for (int c = 2; c < 10; c++) begin
            next_cycle();
            drive_req(1'b0, 32'h0C, 32'h0);
            bus_if.req_valid = (c <= 6);
            bus_if.hready    = (c != 2);
            bus_if.hresp     = (c == 2 || c == 3) ? HRESP_ERROR : HRESP_OKAY;
            bus_if.hrdata    = (c == 8) ? 32'h0BAD_CAFE : $urandom;
            sample();
            if (bus_if.htrans === HTRANS_NONSEQ && bus_if.haddr === 32'h8 && bus_if.hready === 1'b1) leaked++;
            if (c == 2) begin
                tests_run++; if (bus_if.hwdata !== 32'h1111_1111) begin tests_failed++; $display("FAIL ec_hwdata: got %0h want 11111111", bus_if.hwdata); end
            end
            if (c >= 3 && c <= 6) begin
                tests_run++; if (bus_if.htrans !== HTRANS_IDLE) begin tests_failed++; $display("FAIL ec_idle[%0d]: got %0h want 0", c, bus_if.htrans); end
            end
            tests_run++; if (bus_if.req_ready !== (c >= 6)) begin tests_failed++; $display("FAIL ec_ready[%0d]: got %0b want %0b", c, bus_if.req_ready, (c >= 6)); end
            if (c == 4 || c == 5) begin
                tests_run++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_error !== 1'b1 || bus_if.rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL ec_rsp[%0d]: got v=%0b e=%0b d=%0h want 1/1/0", c, bus_if.rsp_valid, bus_if.rsp_error, bus_if.rsp_rdata); end
            end else if (c != 9) begin
                tests_run++; if (bus_if.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL ec_no_rsp[%0d]: got %0b want 0", c, bus_if.rsp_valid); end
            end
            if (c == 7) begin
                tests_run++; if (bus_if.htrans !== HTRANS_NONSEQ || bus_if.haddr !== 32'hC) begin tests_failed++; $display("FAIL ec_resume_addr: got htrans=%0h haddr=%0h want 2/c", bus_if.htrans, bus_if.haddr); end
            end
            if (c == 9) begin
                tests_run++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_error !== 1'b0 || bus_if.rsp_rdata !== 32'h0BAD_CAFE) begin tests_failed++; $display("FAIL ec_resume_rsp: got v=%0b e=%0b d=%0h want 1/0/0badcafe", bus_if.rsp_valid, bus_if.rsp_error, bus_if.rsp_rdata); end
            end
        end
        tests_run++; if (leaked !== 0) begin tests_failed++; $display("FAIL ec_cancelled_issued: got %0d transfers of 0x08 want 0", leaked); end
        idle_cycles(2);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_mid_reset();
        logic [31:0] wd;
        int stray;
        wd = $urandom;
        stray = 0;
        next_cycle();
        drive_req(1'b1, 32'h40, wd);
        sample();
        next_cycle();
        drive_req(1'b0, 32'h44, 32'h0);
        sample();
        next_cycle();
        idle_inputs();
        hresetn = 1'b0;
        sample();
        tests_run++; if (bus_if.hwdata !== wd || bus_if.haddr !== 32'h44) begin tests_failed++; $display("FAIL mr_pre: got hwdata=%0h haddr=%0h want %0h/44", bus_if.hwdata, bus_if.haddr, wd); end
        next_cycle();
        sample();
        tests_run++; if (bus_if.htrans !== HTRANS_IDLE || bus_if.haddr !== 32'h0 || bus_if.hwrite !== 1'b0 || bus_if.hwdata !== 32'h0) begin tests_failed++; $display("FAIL mr_bus: got htrans=%0h haddr=%0h hwrite=%0b hwdata=%0h want all 0", bus_if.htrans, bus_if.haddr, bus_if.hwrite, bus_if.hwdata); end
        tests_run++; if (bus_if.rsp_valid !== 1'b0 || bus_if.rsp_error !== 1'b0 || bus_if.rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL mr_rsp: got v=%0b e=%0b d=%0h want 0/0/0", bus_if.rsp_valid, bus_if.rsp_error, bus_if.rsp_rdata); end
        next_cycle();
        hresetn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            sample();
            if (bus_if.rsp_valid !== 1'b0 || bus_if.htrans !== HTRANS_IDLE) stray++;
        end
        tests_run++; if (stray !== 0) begin tests_failed++; $display("FAIL mr_after: got %0d cycles with activity want 0", stray); end
    endtask

    // -----------------------------------------------------------------------
    // Random reads/writes with random wait states. The model computes each
    // response at acceptance from a flat memory; the slave side serves reads
    // from the memory it builds out of observed hwdata.
    task automatic test_random();
        localparam int NCYC  = 400;
        localparam int DRAIN = 30;
        logic [31:0] exp_q[$];
        logic [31:0] exp_d;
        logic        dp_valid, dp_write;
        logic [31:0] dp_addr;
        logic        prev_hready;
        logic [1:0]  prev_htrans;
        logic [31:0] prev_haddr, prev_hwdata;
        logic        prev_hwrite;
        int          accepted, responded;
        dp_valid = 1'b0; dp_write = 1'b0; dp_addr = '0;
        prev_hready = 1'b1; prev_htrans = '0; prev_haddr = '0; prev_hwdata = '0; prev_hwrite = 1'b0;
        accepted = 0; responded = 0;
        for (int i = 0; i < NCYC + DRAIN; i++) begin
            next_cycle();
            if (i < NCYC) begin
                bus_if.req_valid = ($urandom_range(0, 3) != 0);
                bus_if.req_write = 1'($urandom_range(0, 1));
                bus_if.req_addr  = 32'h200 + (32'($urandom_range(0, 15)) << 2);
                bus_if.req_wdata = $urandom;
                bus_if.hready    = ($urandom_range(0, 3) != 0);
            end else begin
                bus_if.req_valid = 1'b0;
                bus_if.hready    = 1'b1;
            end
            bus_if.hresp  = HRESP_OKAY;
            bus_if.hrdata = (dp_valid && !dp_write && bus_if.hready) ? slave_rd(dp_addr) : $urandom;
            sample();
            tests_run++; if (bus_if.req_ready !== bus_if.hready) begin tests_failed++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, bus_if.req_ready, bus_if.hready); end
            if (!prev_hready) begin
                tests_run++; if (bus_if.htrans !== prev_htrans || bus_if.haddr !== prev_haddr || bus_if.hwrite !== prev_hwrite || bus_if.hwdata !== prev_hwdata) begin tests_failed++; $display("FAIL rnd_hold[%0d]: got %0h/%0h/%0b/%0h want %0h/%0h/%0b/%0h", i, bus_if.htrans, bus_if.haddr, bus_if.hwrite, bus_if.hwdata, prev_htrans, prev_haddr, prev_hwrite, prev_hwdata); end
            end
            if (bus_if.rsp_valid === 1'b1) begin
                responded++;
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
                tests_run++; if (bus_if.rsp_rdata !== exp_d || bus_if.rsp_error !== 1'b0) begin tests_failed++; $display("FAIL rnd_rsp[%0d]: got d=%0h e=%0b want %0h/0", i, bus_if.rsp_rdata, bus_if.rsp_error, exp_d); end
            end
            // Effects of the coming edge.
            if (bus_if.hready) begin
                if (dp_valid && dp_write) slave_mem[dp_addr] = bus_if.hwdata;
                dp_valid = (bus_if.htrans === HTRANS_NONSEQ);
                dp_write = bus_if.hwrite;
                dp_addr  = bus_if.haddr;
            end
            if (bus_if.req_valid && bus_if.req_ready) begin
                accepted++;
                if (bus_if.req_write) begin
                    model_mem[bus_if.req_addr] = bus_if.req_wdata;
                    exp_q.push_back(32'h0);
                end else begin
                    exp_q.push_back(model_rd(bus_if.req_addr));
                end
            end
            prev_hready = bus_if.hready;
            prev_htrans = bus_if.htrans;
            prev_haddr  = bus_if.haddr;
            prev_hwrite = bus_if.hwrite;
            prev_hwdata = bus_if.hwdata;
        end
        tests_run++; if (responded !== accepted || exp_q.size() != 0) begin tests_failed++; $display("FAIL rnd_count: got %0d responses want %0d (%0d pending)", responded, accepted, exp_q.size()); end
        idle_inputs();
    endtask

    // -----------------------------------------------------------------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        hresetn      = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_wait_states();
        test_error_cancel();
        test_mid_reset();
        test_random();
        idle_cycles(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ahb_master_module.md
# ahb_master_module

Single-port AHB-Lite-style bus master: the initiator end of the bus that our slave modules (e.g. slave 2) respond to. It accepts word read/write commands on a valid/ready local interface and drives pipelined AHB address and data phases. It honours `hready` wait states and the two-cycle `hresp` error response. It returns exactly one in-order response per accepted command. It sits between a local controller and the address decoder / slave mux.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

Ports:
- `hclk` in 1: clock. All logic is rising-edge.
- `hresetn` in 1: reset. Synchronous and active-low.
- `req_valid` in 1: local command present.
- `req_ready` out 1: command accepted on the edge when `req_valid & req_ready`.
- `req_write` in 1: 1 means write, 0 means read.
- `req_addr` in ADDR_W: byte address of the command.
- `req_wdata` in DATA_W: write data for the command.
- `rsp_valid` out 1: one-cycle pulse per completed command.
- `rsp_rdata` out DATA_W: read data; 0 for writes.
- `rsp_error` out 1: transfer got ERROR or was cancelled.
- `haddr` out ADDR_W: AHB address.
- `hwrite` out 1: AHB direction.
- `htrans` out 2: 2'b00 IDLE, 2'b10 NONSEQ. No other codes are generated.
- `hsize` out 3: constant 3'b010 (word).
- `hwdata` out DATA_W: AHB write data.
- `hready` in 1: muxed slave `hreadyout`.
- `hresp` in 1: 0 OKAY, 1 ERROR.
- `hrdata` in DATA_W: muxed slave read data.

## Operation
- **Two-stage pipeline.**
  - Address stage (A) holds `{valid, write, addr, wdata}`.
  - Data stage (D) holds `{valid, write, wdata, cancelled}`.
- **Advance.** The pipeline advances only on an edge where `hready=1`:
  - D takes A.
  - A takes the accepted command, or becomes empty.
- **Output drive.** All outputs are registered.
  - `htrans` = NONSEQ when A is valid, else IDLE. `haddr`/`hwrite` come from A.
  - `hwdata` comes from D for writes, else 0.
- **Acceptance.** `req_ready = hready & ~err_blk`. This is the only combinational input-to-output path.
- **Completion.** When D is valid and `hready=1`, the next cycle carries:
  - `rsp_valid=1`
  - `rsp_error=hresp`
  - `rsp_rdata=hrdata` for an OKAY read, else 0.
- **Error.** Detected when D is valid, `hready=0` and `hresp=1` (first error cycle). Then:
  - If A holds NONSEQ, the master drives `htrans=IDLE` from the next cycle, marks A cancelled, and sets `err_blk`.
  - On the second error cycle (`hready=1`), D completes with `rsp_error=1`. The cancelled command moves to D without a bus transfer.
  - On the following cycle the cancelled command responds with `rsp_error=1`, `rsp_rdata=0`.
  - `err_blk` clears after the cancelled response is issued.
- **Ordering.** Responses are strictly in acceptance order, one per command. Cancelled commands are never re-issued.
- **Reset mid-transfer.** Both stages are dropped and no response is produced for in-flight commands.

## Timing
- Reset values:
  - `htrans=IDLE`; `haddr`, `hwrite`, `hwdata` = 0; `hsize=3'b010`.
  - `rsp_valid`, `rsp_error`, `rsp_rdata` = 0.
  - `err_blk=0`; both stages invalid.
  - `req_ready` follows `hready` once out of reset.
- Zero wait states: command accepted at edge N.
  - Cycle N+1: address phase (NONSEQ).
  - Cycle N+2: data phase (`hwdata` valid).
  - Cycle N+3: `rsp_valid`.
- Back-to-back commands give one transfer per cycle. The address phase of k+1 overlaps the data phase of k.
- Each cycle of `hready=0` adds one cycle of latency. During wait states `haddr`, `htrans`, `hwrite` and `hwdata` are held stable.
- Error on transfer k with k+1 pipelined: the two responses arrive on consecutive cycles. `req_ready=0` from the first error cycle through the cancelled response.
- An accept on the same edge that D completes is legal. Only the pipeline advances on that edge.

## Structure
- Shared package `ahb_pkg` holds:
  - `HTRANS_IDLE=2'b00`, `HTRANS_NONSEQ=2'b10`
  - `HRESP_OKAY=1'b0`, `HRESP_ERROR=1'b1`
  - `HSIZE_WORD=3'b010`
  - the A/D stage record typedef, shared with the slaves and the bench
- No sub-module: one flat module holding the pipeline registers and the `err_blk` flag.

## Test plan
- **Single write.** Write 0x10 ← 0xDEADBEEF, `hready=1`:
  - NONSEQ/`haddr=0x10` one cycle after accept.
  - `hwdata=0xDEADBEEF` the next cycle.
  - `rsp_valid`, `rsp_error=0` at accept+3.
- **Single read.** Read 0x14, slave returns 0x12345678: `rsp_rdata=0x12345678`, `rsp_error=0`.
- **Back-to-back.** Four writes on consecutive cycles:
  - NONSEQ on 4 consecutive cycles.
  - 4 responses on consecutive cycles, in order.
- **Wait states.** `hready=0` for 3 cycles during a read's data phase:
  - Address and `hwdata` held stable.
  - `req_ready=0`.
  - Response delayed by exactly 3 cycles.
- **Error cancel.** Write to 0x00 gets ERROR while a read of 0x08 is pipelined:
  - `htrans=IDLE` from the cycle after the first error cycle.
  - Two consecutive responses, both `rsp_error=1`.
  - 0x08 never appears with NONSEQ.
- **Mid-transfer reset.** `hresetn=0` during a data phase:
  - Next cycle: `htrans=IDLE`, all outputs at reset values.
  - No `rsp_valid`.
